// File: rtl/sic_dispatcher_pkg.sv
// Shared types for the SIC dispatch path: renamed packet layout, opcode/funct
// constants and the dispatcher's JR-hold state encoding.
package sic_dispatcher_pkg;

  localparam int SIC_ID_W = 8;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_ADDI    = 6'h08;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_SW      = 6'h2b;

  localparam logic [5:0] FUNCT_JR    = 6'h08;

  typedef struct packed {
    logic                valid;
    logic [SIC_ID_W-1:0] issue_id;
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [5:0]          prs;
    logic [5:0]          prt;
    logic [5:0]          prd;
    logic [15:0]         imm;
    logic [31:0]         pc;
  } sic_packet_t;

  typedef enum logic [0:0] {
    DS_RUN     = 1'b0,
    DS_JR_WAIT = 1'b1
  } disp_state_e;

  function automatic logic is_jr(input sic_packet_t p);
    return (p.opcode == OPC_SPECIAL) && (p.funct == FUNCT_JR);
  endfunction

endpackage

// File: rtl/sic_dispatch_fifo.sv
// Two-entry packet FIFO in front of the dispatcher. Flush (redirect) wins over
// push and pop in the same cycle.
module sic_dispatch_fifo
  import sic_dispatcher_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  sic_packet_t wr_data,
  output logic        full,
  output logic        empty,
  output sic_packet_t head
);

  sic_packet_t mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        do_push;
  logic        do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  // A push at full is only safe when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/sic_dispatcher.sv
// Buffers renamed packets, stamps issue IDs and hands each to one ready SIC per
// cycle; holds dispatch after a JR until its redirect. Optional SIC_DISPATCH_STATS_EN.
module sic_dispatcher
  import sic_dispatcher_pkg::*;
#(
  parameter int NUM_SIC  = 4,
  parameter int ID_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  sic_packet_t                        in_pkt,
  input  logic [NUM_SIC-1:0]                 req_instr,
  output sic_packet_t [NUM_SIC-1:0]          packet_out,
  input  logic [NUM_SIC-1:0]                 pc_redirect_valid,
  input  logic [NUM_SIC-1:0][31:0]           pc_redirect_pc,
  input  logic [NUM_SIC-1:0][ID_WIDTH-1:0]   pc_redirect_issue_id,
  output logic                               fetch_redirect_valid,
  output logic [31:0]                        fetch_redirect_pc,
  output logic                               jr_pending
`ifdef SIC_DISPATCH_STATS_EN
  ,
  output logic [31:0]                        stat_dispatched,
  output logic [31:0]                        stat_stall_cycles
`endif
);

  localparam int PTR_W = (NUM_SIC > 1) ? $clog2(NUM_SIC) : 1;

  // Handshakes: upstream transfers when in_valid && in_ready in the same cycle,
  // in_valid must not depend on in_ready; a SIC receives a packet only when its
  // req_instr has been high for two consecutive cycles, and packet_out.valid is
  // a single-cycle strobe with no back-pressure from the SIC.

  disp_state_e            state_q, state_d;
  logic [NUM_SIC-1:0]     req_q;
  logic [NUM_SIC-1:0]     ready;
  logic [PTR_W-1:0]       rr_ptr_q;
  logic [ID_WIDTH-1:0]    id_cnt_q;
  logic [ID_WIDTH-1:0]    jr_id_q;
  logic                   frv_q;
  logic [31:0]            frpc_q;

  logic                   fifo_full, fifo_empty;
  sic_packet_t            head;
  logic                   push, dispatch, redirect_hit;
  logic                   hit_any;
  logic [31:0]            hit_pc;
  logic                   found;
  logic [PTR_W-1:0]       target, cand;

  assign ready = req_instr & req_q;

  sic_dispatch_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (dispatch),
    .flush   (redirect_hit),
    .wr_data (in_pkt),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head)
  );

  // Lowest-index matching redirect wins: scan high to low, last write sticks.
  always_comb begin
    hit_any = 1'b0;
    hit_pc  = '0;
    for (int i = NUM_SIC - 1; i >= 0; i--) begin
      if (pc_redirect_valid[i] && (pc_redirect_issue_id[i] == jr_id_q)) begin
        hit_any = 1'b1;
        hit_pc  = pc_redirect_pc[i];
      end
    end
  end

  assign redirect_hit = !rst && (state_q == DS_JR_WAIT) && hit_any;
  assign in_ready     = !rst && !fifo_full && !redirect_hit;
  assign push         = in_valid && in_ready;

  // Round-robin: first ready SIC at or after rr_ptr_q, wrapping.
  always_comb begin
    found  = 1'b0;
    target = '0;
    cand   = '0;
    for (int k = 0; k < NUM_SIC; k++) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_SIC);
      if (!found && ready[cand]) begin
        found  = 1'b1;
        target = cand;
      end
    end
  end

  assign dispatch = !rst && !fifo_empty && (state_q == DS_RUN) && !redirect_hit && found;

  always_comb begin
    for (int i = 0; i < NUM_SIC; i++) begin
      packet_out[i]          = head;
      packet_out[i].valid    = 1'b0;
      packet_out[i].issue_id = SIC_ID_W'(id_cnt_q);
    end
    if (dispatch) packet_out[target].valid = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_RUN:     if (dispatch && is_jr(head)) state_d = DS_JR_WAIT;
      DS_JR_WAIT: if (redirect_hit)            state_d = DS_RUN;
      default:                                 state_d = DS_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DS_RUN;
      req_q    <= '0;
      rr_ptr_q <= '0;
      id_cnt_q <= '0;
      jr_id_q  <= '0;
      frv_q    <= 1'b0;
      frpc_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_instr;
      frv_q   <= redirect_hit;
      if (redirect_hit) frpc_q <= hit_pc;
      if (dispatch) begin
        rr_ptr_q <= PTR_W'((int'(target) + 1) % NUM_SIC);
        id_cnt_q <= id_cnt_q + ID_WIDTH'(1);
        if (is_jr(head)) jr_id_q <= id_cnt_q;
      end
    end
  end

  // Registered outputs are also forced low during the reset cycle itself.
  assign jr_pending           = !rst && (state_q == DS_JR_WAIT);
  assign fetch_redirect_valid = !rst && frv_q;
  assign fetch_redirect_pc    = rst ? 32'h0 : frpc_q;

`ifdef SIC_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_dispatched   <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (dispatch && (stat_dispatched != 32'hffff_ffff))
        stat_dispatched <= stat_dispatched + 32'd1;
      if (!fifo_empty && !dispatch && (stat_stall_cycles != 32'hffff_ffff))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sic_dispatcher.sv
// Directed bench for sic_dispatcher: vector table for intake/round-robin/backpressure,
// hand sequences for JR hold, redirect flush and mid-operation reset.
module tb_sic_dispatcher;
  import sic_dispatcher_pkg::*;

  localparam int NS = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid;
  logic                   in_ready, in_ready_w2;
  sic_packet_t            in_pkt;
  logic [NS-1:0]          req_instr;
  sic_packet_t [NS-1:0]   packet_out, packet_out_w2;
  logic [NS-1:0]          pc_redirect_valid;
  logic [NS-1:0][31:0]    pc_redirect_pc;
  logic [NS-1:0][7:0]     pc_redirect_issue_id;
  logic [NS-1:0][1:0]     rid_w2;
  logic                   frv, frv_w2, jr_pending, jr_pending_w2;
  logic [31:0]            frpc, frpc_w2;
`ifdef SIC_DISPATCH_STATS_EN
  logic [31:0]            stat_disp, stat_stall, stat_disp_w2, stat_stall_w2;
`endif

  int checks = 0;
  int failures = 0;
  logic sb_en = 1'b0;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < NS; i++) rid_w2[i] = pc_redirect_issue_id[i][1:0];

  sic_dispatcher #(.NUM_SIC(NS), .ID_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
    .req_instr(req_instr), .packet_out(packet_out),
    .pc_redirect_valid(pc_redirect_valid), .pc_redirect_pc(pc_redirect_pc),
    .pc_redirect_issue_id(pc_redirect_issue_id),
    .fetch_redirect_valid(frv), .fetch_redirect_pc(frpc), .jr_pending(jr_pending)
`ifdef SIC_DISPATCH_STATS_EN
    , .stat_dispatched(stat_disp), .stat_stall_cycles(stat_stall)
`endif
  );

  sic_dispatcher #(.NUM_SIC(NS), .ID_WIDTH(2)) dut_w2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w2), .in_pkt(in_pkt),
    .req_instr(req_instr), .packet_out(packet_out_w2),
    .pc_redirect_valid(pc_redirect_valid), .pc_redirect_pc(pc_redirect_pc),
    .pc_redirect_issue_id(rid_w2),
    .fetch_redirect_valid(frv_w2), .fetch_redirect_pc(frpc_w2), .jr_pending(jr_pending_w2)
`ifdef SIC_DISPATCH_STATS_EN
    , .stat_dispatched(stat_disp_w2), .stat_stall_cycles(stat_stall_w2)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic sic_packet_t mk_pkt(input logic [15:0] imm, input logic jr);
    sic_packet_t p;
    p          = '0;
    p.valid    = 1'b1;
    p.issue_id = 8'hee;
    p.opcode   = jr ? OPC_SPECIAL : OPC_ADDI;
    p.funct    = jr ? FUNCT_JR : 6'h00;
    p.imm      = imm;
    p.pc       = 32'h0040_0000 + {14'h0, imm, 2'b00};
    return p;
  endfunction

  function automatic logic [NS-1:0] vld(input sic_packet_t [NS-1:0] po);
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = po[i].valid;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    req_instr = '0;
    pc_redirect_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (sb_en) begin
      for (int i = 0; i < NS; i++) begin
        if (packet_out[i].valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: got dispatch to sic %0d id %0h expected none", i, packet_out[i].issue_id);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("sb_issue_id", packet_out[i].issue_id, e);
          end
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        iv;
    logic [15:0] imm;
    logic [3:0]  req;
    logic        rdy;
    logic [3:0]  ev;
    logic [7:0]  eid;
    logic [15:0] eimm;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic iv, input logic [15:0] imm,
                              input logic [3:0] req, input logic rdy, input logic [3:0] ev,
                              input logic [7:0] eid, input logic [15:0] eimm);
    vec_t v;
    v.rst = r; v.iv = iv; v.imm = imm; v.req = req;
    v.rdy = rdy; v.ev = ev; v.eid = eid; v.eimm = eimm;
    return v;
  endfunction

  localparam int NV = 24;
  vec_t vec [NV];

  initial begin
    #200000;
    checks++;
    failures++;
    $display("FAIL timeout: got no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int t;
    // reset
    vec[0]  = mk(1, 0, 16'd0,  4'h0, 0, 4'h0, 8'd0, 16'd0);
    vec[1]  = mk(1, 1, 16'd99, 4'hf, 0, 4'h0, 8'd0, 16'd0);
    // round robin 0,1,2,3 then back to 0
    vec[2]  = mk(0, 1, 16'd10, 4'hf, 1, 4'h0, 8'd0, 16'd0);
    vec[3]  = mk(0, 1, 16'd11, 4'hf, 1, 4'h1, 8'd0, 16'd10);
    vec[4]  = mk(0, 1, 16'd12, 4'hf, 1, 4'h2, 8'd1, 16'd11);
    vec[5]  = mk(0, 1, 16'd13, 4'hf, 1, 4'h4, 8'd2, 16'd12);
    vec[6]  = mk(0, 0, 16'd0,  4'hf, 1, 4'h8, 8'd3, 16'd13);
    vec[7]  = mk(0, 0, 16'd0,  4'hf, 1, 4'h0, 8'd0, 16'd0);
    vec[8]  = mk(0, 1, 16'd14, 4'hf, 1, 4'h0, 8'd0, 16'd0);
    vec[9]  = mk(0, 0, 16'd0,  4'hf, 1, 4'h1, 8'd4, 16'd14);
    // req rise on SIC1: dispatch one cycle after the rise
    vec[10] = mk(1, 0, 16'd0,  4'h0, 0, 4'h0, 8'd0, 16'd0);
    vec[11] = mk(0, 1, 16'd20, 4'h0, 1, 4'h0, 8'd0, 16'd0);
    vec[12] = mk(0, 0, 16'd0,  4'h2, 1, 4'h0, 8'd0, 16'd0);
    vec[13] = mk(0, 0, 16'd0,  4'h2, 1, 4'h2, 8'd0, 16'd20);
    vec[14] = mk(0, 0, 16'd0,  4'h0, 1, 4'h0, 8'd0, 16'd0);
    // backpressure: no SIC ready, third packet held
    vec[15] = mk(0, 1, 16'd30, 4'h0, 1, 4'h0, 8'd0, 16'd0);
    vec[16] = mk(0, 1, 16'd31, 4'h0, 1, 4'h0, 8'd0, 16'd0);
    vec[17] = mk(0, 1, 16'd32, 4'h0, 0, 4'h0, 8'd0, 16'd0);
    vec[18] = mk(0, 1, 16'd32, 4'h0, 0, 4'h0, 8'd0, 16'd0);
    vec[19] = mk(0, 1, 16'd32, 4'h1, 0, 4'h0, 8'd0, 16'd0);
    vec[20] = mk(0, 1, 16'd32, 4'h1, 0, 4'h1, 8'd1, 16'd30);
    vec[21] = mk(0, 1, 16'd32, 4'h1, 1, 4'h1, 8'd2, 16'd31);
    vec[22] = mk(0, 0, 16'd0,  4'h1, 1, 4'h1, 8'd3, 16'd32);
    vec[23] = mk(0, 0, 16'd0,  4'h0, 1, 4'h0, 8'd0, 16'd0);

    in_valid = 1'b0;
    in_pkt = '0;
    req_instr = '0;
    pc_redirect_valid = '0;
    pc_redirect_pc = '0;
    pc_redirect_issue_id = '0;
    tick();

    for (int r = 0; r < NV; r++) begin
      rst       = vec[r].rst;
      in_valid  = vec[r].iv;
      in_pkt    = mk_pkt(vec[r].imm, 1'b0);
      req_instr = vec[r].req;
      #1;
      chk($sformatf("r%0d_in_ready", r), in_ready, vec[r].rdy);
      chk($sformatf("r%0d_valid", r), vld(packet_out), vec[r].ev);
      chk($sformatf("r%0d_w2_valid", r), vld(packet_out_w2), vec[r].ev);
      chk($sformatf("r%0d_frv", r), frv, 1'b0);
      chk($sformatf("r%0d_jr_pending", r), jr_pending, 1'b0);
      if (vec[r].ev != 4'h0) begin
        t = 0;
        for (int i = 0; i < NS; i++) if (vec[r].ev[i]) t = i;
        chk($sformatf("r%0d_issue_id", r), packet_out[t].issue_id, vec[r].eid);
        chk($sformatf("r%0d_imm", r), packet_out[t].imm, vec[r].eimm);
        chk($sformatf("r%0d_w2_issue_id", r), packet_out_w2[t].issue_id, {6'h0, vec[r].eid[1:0]});
      end
      if (vec[r].rst) chk($sformatf("r%0d_frpc", r), frpc, 32'h0);
      tick();
    end
`ifdef SIC_DISPATCH_STATS_EN
    chk("stat_dispatched", stat_disp, 32'd4);
    chk("stat_stall_cycles", stat_stall, 32'd5);
`endif

    // ---------------- JR hold and redirect flush ----------------
    do_reset();
    sb_en = 1'b1;
    for (int k = 0; k < 6; k++) exp_q.push_back(8'(k));
    req_instr = '1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_pkt   = mk_pkt(16'(100 + k), k == 5);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("jr_hold_pending", jr_pending, 1'b1);
    chk("jr_hold_full", in_ready, 1'b0);
    chk("jr_hold_no_valid", vld(packet_out), 4'h0);
    chk("jr_sb_drained", exp_q.size(), 0);

    pc_redirect_valid = 4'b0100;
    pc_redirect_issue_id[2] = 8'd4;
    pc_redirect_pc[2] = 32'h0040_0200;
    #1;
    chk("jr_ignored_in_ready", in_ready, 1'b0);
    tick();
    pc_redirect_valid = '0;
    #1;
    chk("jr_ignored_frv", frv, 1'b0);
    chk("jr_ignored_pending", jr_pending, 1'b1);

    pc_redirect_valid = 4'b1100;
    pc_redirect_issue_id[2] = 8'd5;
    pc_redirect_pc[2] = 32'h0040_0100;
    pc_redirect_issue_id[3] = 8'd5;
    pc_redirect_pc[3] = 32'h0040_0300;
    #1;
    chk("jr_hit_in_ready", in_ready, 1'b0);
    chk("jr_hit_no_valid", vld(packet_out), 4'h0);
    tick();
    pc_redirect_valid = '0;
    #1;
    chk("jr_redirect_valid", frv, 1'b1);
    chk("jr_redirect_pc", frpc, 32'h0040_0100);
    chk("jr_cleared", jr_pending, 1'b0);
    chk("jr_flushed_in_ready", in_ready, 1'b1);
    chk("jr_flushed_no_valid", vld(packet_out), 4'h0);
    tick();
    #1;
    chk("jr_redirect_pulse_end", frv, 1'b0);

    // ---------------- mid-operation reset ----------------
    exp_q.push_back(8'd6);
    in_valid = 1'b1;
    in_pkt = mk_pkt(16'd200, 1'b1);
    tick();
    in_pkt = mk_pkt(16'd201, 1'b0);
    tick();
    in_pkt = mk_pkt(16'd202, 1'b0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("mr_pre_pending", jr_pending, 1'b1);
    chk("mr_pre_full", in_ready, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1;
    pc_redirect_valid = 4'b0001;
    pc_redirect_issue_id[0] = 8'd6;
    pc_redirect_pc[0] = 32'h0040_0400;
    #1;
    chk("mr_rst_in_ready", in_ready, 1'b0);
    chk("mr_rst_valid", vld(packet_out), 4'h0);
    chk("mr_rst_pending", jr_pending, 1'b0);
    chk("mr_rst_frv", frv, 1'b0);
    chk("mr_rst_frpc", frpc, 32'h0);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    pc_redirect_valid = '0;
    #1;
    chk("mr_post_frv", frv, 1'b0);
    chk("mr_post_pending", jr_pending, 1'b0);
    chk("mr_post_in_ready", in_ready, 1'b1);
    tick();
    #1;
    chk("mr_post_empty", vld(packet_out), 4'h0);
    exp_q.push_back(8'd0);
    in_valid = 1'b1;
    in_pkt = mk_pkt(16'd210, 1'b0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("mr_first_valid", vld(packet_out), 4'h1);
    chk("mr_first_id", packet_out[0].issue_id, 8'd0);
    tick();
    #1;
    chk("mr_sb_drained", exp_q.size(), 0);
    sb_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sic_dispatcher.md
Name: sic_dispatcher

Overview:
- Sits between the fetch/decode/rename front end and the array of single-instruction controllers (SICs).
- Accepts renamed packets over a valid/ready stream and buffers them in a 2-entry FIFO.
- Stamps each packet with a monotonically wrapping issue ID and hands it to one ready SIC per cycle, using that SIC's req_instr / packet valid handshake.
- After issuing a JR, halts dispatch until the owning SIC reports its PC redirect, then flushes wrong-path packets and forwards the redirect to fetch.

Parameters:
- NUM_SIC, 4, number of SICs served.
- ID_WIDTH, 8, issue ID width; must match the SICs.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  upstream packet valid
- in_ready  out  1  FIFO can accept
- in_pkt  in  sic_packet_t  renamed packet; valid and issue_id fields ignored
- req_instr  in  [NUM_SIC]  per-SIC request for an instruction
- packet_out  out  sic_packet_t [NUM_SIC]  per-SIC packet; .valid is the strobe
- pc_redirect_valid  in  [NUM_SIC]  SIC JR commit redirect
- pc_redirect_pc  in  32 [NUM_SIC]  redirect target
- pc_redirect_issue_id  in  ID_WIDTH [NUM_SIC]  issue ID of the redirecting JR
- fetch_redirect_valid  out  1  one-cycle redirect pulse to fetch
- fetch_redirect_pc  out  32  redirect target
- jr_pending  out  1  dispatch halted awaiting JR redirect

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous, active-high.
  - While rst is high or in its cycle: FIFO empty; in_ready=0; all packet_out.valid=0; fetch_redirect_valid=0; fetch_redirect_pc=0; jr_pending=0; issue-ID counter=0; RR pointer=0; req_q=0.
  - rst asserted mid-operation discards everything; no pulses are emitted.
- Intake:
  - in_ready = !full && !redirect_hit.
  - A push occurs when in_valid && in_ready.
  - Pushing while popping in the same cycle is legal at count=2, but in_ready still reflects full.
- SIC readiness:
  - req_q[i] is req_instr[i] registered each cycle.
  - ready[i] = req_instr[i] && req_q[i], i.e. the SIC has passed IDLE and is in WAIT_PACKET.
  - A SIC must never receive valid during its IDLE cycle.
- Dispatch (combinational output, same cycle as the pop):
  - Dispatch occurs when FIFO is non-empty, !jr_pending, !redirect_hit, and some ready[i] is set.
  - Target is the first ready index at or after the RR pointer, wrapping.
  - packet_out[target] = FIFO head with valid=1 and issue_id=counter; all other packet_out.valid=0.
  - The head is popped, the counter increments (wrapping at 2^ID_WIDTH), and the RR pointer moves to target+1 mod NUM_SIC.
  - At most one dispatch per cycle.
  - packet_out payload for non-targeted SICs is don't-care, driven as the head with valid=0.
- JR hold:
  - If the dispatched head is SPECIAL with funct=FUNCT_JR: jr_pending<=1 and jr_id<=issued ID.
- redirect_hit:
  - Asserted when jr_pending and any pc_redirect_valid[i] has pc_redirect_issue_id[i]==jr_id.
  - If several match, the lowest i wins.
  - Non-matching redirects are ignored.
- On redirect_hit, next edge:
  - FIFO flushed;
  - jr_pending<=0;
  - fetch_redirect_valid<=1 for one cycle;
  - fetch_redirect_pc<=the matching pc.
  - No push or dispatch occurs in the hit cycle.
- Empty FIFO or no ready SIC: no dispatch, state holds.

Optional Feature:
- Macro: SIC_DISPATCH_STATS_EN.
- When defined:
  - Adds outputs stat_dispatched (32) and stat_stall_cycles (32), both reset to 0 and saturating.
  - stat_dispatched increments per dispatch.
  - stat_stall_cycles increments each cycle the FIFO is non-empty but no dispatch occurs.
- When undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package:
  - sic_packet_t and the OPC_* constants already live there.
  - Add FUNCT_JR=6'h08 there.
- Sub-module sic_dispatch_fifo:
  - 2-entry sic_packet_t FIFO with push, pop, flush, full, empty, head.
  - Flush has priority over push and pop.

Test Plan:
- Req rise: NUM_SIC=4; SIC1 raises req at cycle t; one packet queued → packet_out[1].valid=1 at t+1 (not t) with issue_id=0; no other valid.
- Round-robin: SICs 0–3 all ready, 4 packets queued → dispatch to 0,1,2,3 on consecutive cycles with issue_id 0,1,2,3; pointer returns to 0.
- ID wrap: ID_WIDTH=2, 5 dispatches → issue_id sequence 0,1,2,3,0.
- JR hold: dispatch JR (id 5), then push 2 more packets → no dispatch and jr_pending=1. SIC2 sends redirect with id 4 → ignored. SIC2 sends redirect with id 5, pc 0x00400100 → next cycle fetch_redirect_valid=1, pc=0x00400100, FIFO empty, jr_pending=0.
- Backpressure: no SIC ready, push 3 packets → in_ready drops after the second; the third is held by the source; stat_stall_cycles counts (with SIC_DISPATCH_STATS_EN).
- Mid reset: rst=1 while 2 packets are queued and jr_pending=1 → next cycle everything is cleared, no valid or redirect pulses, first dispatch after release has issue_id=0.
